switch_issue_sequencer: RTL
===========================

SWITCH_ISSUE_SEQUENCER -- requirements
Module: switch_issue_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, the width of one element lane.
REQ-002 SHALL have parameter NUM_PE, default 8, the number of lanes per batch.
REQ-003 SHALL have parameter SW_LATENCY, default 8, the cycles from sw_valid to the batch appearing at the switch network output.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, the number of batch entries; must be a power of two and at least 2.
REQ-005 SHALL have parameter CREDITS, default 8, the number of downstream batch slots.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port in_valid, input, 1 bit: the upstream batch is valid.
REQ-009 SHALL have port in_ready, output, 1 bit: the FIFO can accept a batch.
REQ-010 SHALL have port in_data, input, NUM_PE x DATA_WIDTH unpacked array: one element per PE.
REQ-011 SHALL have port in_mode, input, 1 bit: the switch ctrl value that this batch requires.
REQ-012 SHALL have port sw_ctrl, output, 1 bit: the global ctrl driven to the switch network.
REQ-013 SHALL have port sw_data, output, NUM_PE x DATA_WIDTH unpacked array: the batch driven into the switch network.
REQ-014 SHALL have port sw_valid, output, 1 bit: sw_data holds a newly issued batch.
REQ-015 SHALL have port out_valid, output, 1 bit: asserted when the network output carries an issued batch.
REQ-016 SHALL have port credit_return, input, 1 bit: a one-cycle pulse meaning one downstream slot was freed.
REQ-017 SHALL have port busy, output, 1 bit: asserted when state is not IDLE or any batch is in flight.

Function
REQ-018 SHALL push {in_mode, in_data} into the FIFO when in_valid && in_ready; in_ready = !full, with no pass-through when full.
REQ-019 SHALL implement FSM states IDLE, ISSUE, DRAIN and FLIP.
REQ-020 SHALL move IDLE->ISSUE when the FIFO is non-empty.
REQ-021 SHALL move ISSUE->DRAIN when the head mode != sw_ctrl.
REQ-022 SHALL move ISSUE->IDLE when the FIFO is empty.
REQ-023 SHALL move DRAIN->FLIP when the in-flight count is 0.
REQ-024 SHALL, in FLIP, set sw_ctrl <= ~sw_ctrl for exactly one cycle, then move to ISSUE.
REQ-025 SHALL issue in ISSUE when the FIFO is non-empty, head mode == sw_ctrl and credits > 0: pop the head, register it into sw_data, and pulse sw_valid high for one cycle.
REQ-026 SHALL issue at most one batch per cycle, back-to-back issues allowed; sw_data holds its last value when not issuing.
REQ-027 SHALL assert out_valid exactly SW_LATENCY cycles after the corresponding sw_valid, via a SW_LATENCY-deep valid shift register.
REQ-028 SHALL compute in-flight count = sw_valid plus the number of ones in the shift register; sw_ctrl never changes while in-flight count is nonzero.
REQ-029 SHALL hold a credit counter of width clog2(CREDITS+1): decrement on issue, increment on credit_return, unchanged when both occur in one cycle, and saturate at CREDITS by ignoring an excess return.
REQ-030 SHALL, at credits = 0, stall in ISSUE with no sw_valid until a credit_return arrives.
REQ-031 SHALL, on simultaneous push and issue at the full boundary, accept the pop and refuse the push, since in_ready was low.

Reset
REQ-032 SHALL, on rst: state IDLE, FIFO empty, in_ready=1, sw_ctrl=0, sw_valid=0, sw_data=0, shift register cleared, out_valid=0, credits=CREDITS, busy=0.
REQ-033 SHALL, on rst mid-operation, discard in-flight batches and queued batches, with out_valid low asynchronously, and raise no credit_return expectations.

Configuration
REQ-034 SHALL, with SWITCH_SEQ_STATS_EN defined, add 32-bit outputs stat_batches (count of issues) and stat_drain_cycles (count of cycles in DRAIN), both reset to 0 and wrapping on overflow.
REQ-035 SHALL, without SWITCH_SEQ_STATS_EN, omit those ports and counters, with all other behaviour identical.

Verification
REQ-036 SHALL cover: 3 batches, mode 0, credits 8 -> sw_valid on 3 consecutive cycles and out_valid on 3 consecutive cycles 8 cycles later; sw_ctrl stays 0.
REQ-037 SHALL cover: batch mode 0 then batch mode 1 -> DRAIN until out_valid of the first batch falls, then FLIP; sw_ctrl=1 and the second batch issues on the cycle after FLIP.
REQ-038 SHALL cover: CREDITS=2 with 4 batches queued and no returns -> exactly 2 issues; a credit_return pulse -> exactly 1 more issue.
REQ-039 SHALL cover: credit_return and issue in the same cycle with credits=1 -> credits stay 1; a return at credits=8 -> stays 8.
REQ-040 SHALL cover: 5 pushes with no issue (credits 0) and FIFO_DEPTH=4 -> in_ready low after 4, the 5th held until a pop.
REQ-041 SHALL cover: rst asserted mid-DRAIN -> all outputs at reset values immediately; no out_valid after release.

Source files
------------

// File: rtl/switch_issue_sequencer.sv
// ============================================================================
//  Module      : switch_issue_sequencer
//  Description : Queues PE batches and issues them into a global-ctrl switch
//                network. The ctrl flips only once the network is empty. Issue
//                is credit-gated against downstream slots. Optional stats
//                counters are enabled by SWITCH_SEQ_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_issue_sequencer #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_PE     = 8,
    parameter int SW_LATENCY = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CREDITS    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data [NUM_PE],
    input  logic                  in_mode,
    output logic                  sw_ctrl,
    output logic [DATA_WIDTH-1:0] sw_data [NUM_PE],
    output logic                  sw_valid,
    output logic                  out_valid,
    input  logic                  credit_return,
    output logic                  busy
`ifdef SWITCH_SEQ_STATS_EN
    ,
    output logic [31:0]           stat_batches,
    output logic [31:0]           stat_drain_cycles
`endif
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int CRED_W = $clog2(CREDITS + 1);
    localparam int INF_W  = $clog2(SW_LATENCY + 2);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CRED_W-1:0] CREDITS_C = CRED_W'(CREDITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FLIP  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH][NUM_PE];
    logic [FIFO_DEPTH-1:0] mode_mem;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CRED_W-1:0]     credits;
    logic [SW_LATENCY-1:0] valid_pipe;
    logic [INF_W-1:0]      inflight;
    logic                  push, pop, empty, full, head_mode;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign head_mode = mode_mem[rd_ptr];
    assign out_valid = valid_pipe[SW_LATENCY-1];
    assign busy      = (state != IDLE) || (inflight != '0);

    // Storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= in_data;
            mode_mem[wr_ptr] <= in_mode;
        end
    end

    always_comb begin
        inflight = INF_W'(sw_valid);
        for (int i = 0; i < SW_LATENCY; i++) begin
            inflight = inflight + INF_W'(valid_pipe[i]);
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) state_next = ISSUE;
            end
            ISSUE: begin
                if (empty)                        state_next = IDLE;
                else if (head_mode != sw_ctrl)    state_next = DRAIN;
                else if (credits != '0)           pop        = 1'b1;
            end
            DRAIN: begin
                if (inflight == '0) state_next = FLIP;
            end
            FLIP: begin
                state_next = ISSUE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            sw_ctrl    <= 1'b0;
            sw_valid   <= 1'b0;
            valid_pipe <= '0;
            credits    <= CREDITS_C;
            for (int i = 0; i < NUM_PE; i++) begin
                sw_data[i] <= '0;
            end
        end else begin
            state    <= state_next;
            sw_valid <= pop;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                sw_data <= data_mem[rd_ptr];
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (state == FLIP) sw_ctrl <= ~sw_ctrl;

            valid_pipe[0] <= sw_valid;
            for (int i = 1; i < SW_LATENCY; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
            end

            // A return arriving while already full of credits is dropped.
            if (pop && !credit_return)
                credits <= credits - CRED_W'(1);
            else if (!pop && credit_return && credits != CREDITS_C)
                credits <= credits + CRED_W'(1);
        end
    end

`ifdef SWITCH_SEQ_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_batches      <= '0;
            stat_drain_cycles <= '0;
        end else begin
            if (pop)            stat_batches      <= stat_batches + 32'd1;
            if (state == DRAIN) stat_drain_cycles <= stat_drain_cycles + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire
